// File: rtl/uart_cmd.sv
// Host-side UART command processor: parses 'W' AH AL D / 'R' AH AL byte commands,
// masters the internal memory port and returns one response byte per command.
// Optional inter-byte timeout ('!' response) enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 270000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rx_rdy_i,
    input  logic [7:0]        rx_dat_i,
    output logic              rd_o,
    input  logic              tx_bsy_i,
    output logic              wr_o,
    output logic [7:0]        tx_dat_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_dat_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_dat_i
);

    localparam int unsigned AH_W = ADDR_W - 8;
    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    if (ADDR_W < 9 || ADDR_W > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1048575) begin : g_param_chk
        $error("uart_cmd: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_GET_AH, S_GET_AL, S_GET_D, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_SEND
    } state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic              rd_q, wr_q;
    logic              op_wr_q, op_wr_d;
    logic [AH_W-1:0]   ah_q, ah_d;
    logic [7:0]        al_q, al_d;
    logic [7:0]        tx_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        mdat_d;
    logic              we_d, re_d;
    logic              get_st_c;
    logic              accept_c;
    logic              send_c;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Byte hand-shakes are same-cycle: rd_o acknowledges the byte being captured, wr_o the byte being sent.
    assign get_st_c = (state_q == S_GET_AH) || (state_q == S_GET_AL) || (state_q == S_GET_D);
    assign accept_c = run_q && rx_rdy_i && !rd_q && ((state_q == S_IDLE) || get_st_c);
    assign send_c   = run_q && (state_q == S_SEND) && !tx_bsy_i && !wr_q;
    assign rd_o     = accept_c;
    assign wr_o     = send_c;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            op_wr_q    <= 1'b0;
            ah_q       <= '0;
            al_q       <= '0;
            tx_dat_o   <= '0;
            mem_addr_o <= '0;
            mem_dat_o  <= '0;
            mem_we_o   <= 1'b0;
            mem_re_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            rd_q       <= accept_c;
            wr_q       <= send_c;
            op_wr_q    <= op_wr_d;
            ah_q       <= ah_d;
            al_q       <= al_d;
            tx_dat_o   <= tx_d;
            mem_addr_o <= addr_d;
            mem_dat_o  <= mdat_d;
            mem_we_o   <= we_d;
            mem_re_o   <= re_d;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state and register-load decode.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        ah_d    = ah_q;
        al_d    = al_q;
        tx_d    = tx_dat_o;
        addr_d  = mem_addr_o;
        mdat_d  = mem_dat_o;
        we_d    = 1'b0;
        re_d    = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (rx_dat_i == OP_WR || rx_dat_i == OP_RD) begin
                        op_wr_d = (rx_dat_i == OP_WR);
                        state_d = S_GET_AH;
                    end else begin
                        tx_d    = RSP_BAD;
                        state_d = S_SEND;
                    end
                end
            end
            S_GET_AH: begin
                if (accept_c) begin
                    ah_d    = rx_dat_i[AH_W-1:0];
                    state_d = S_GET_AL;
                end
            end
            S_GET_AL: begin
                if (accept_c) begin
                    al_d = rx_dat_i;
                    if (op_wr_q) begin
                        state_d = S_GET_D;
                    end else begin
                        addr_d  = {ah_q, rx_dat_i};
                        re_d    = 1'b1;
                        state_d = S_BUS_RD;
                    end
                end
            end
            S_GET_D: begin
                if (accept_c) begin
                    addr_d  = {ah_q, al_q};
                    mdat_d  = rx_dat_i;
                    we_d    = 1'b1;
                    state_d = S_BUS_WR;
                end
            end
            S_BUS_WR: begin
                tx_d    = RSP_OK;
                state_d = S_SEND;
            end
            S_BUS_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_d    = mem_dat_i;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (send_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef UART_CMD_TIMEOUT_EN
        // Stalled partial command: drop it and answer '!' once the counter expires.
        if (get_st_c && !accept_c) begin
            if (cnt_q == CNT_LAST) begin
                tx_d    = 8'h21;
                state_d = S_SEND;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

endmodule
